// File: rtl/nco_iq.sv
// nco_iq: phase-accumulator NCO producing quadrature sine/cosine samples
// from one shared quarter-wave magnitude ROM.
//
// Pipeline (sample accepted on edge k, output on edge k+3):
//   A  phase accumulate + per-sample offset
//   B  quadrant fold into ROM address + negate flag (sin and cos)
//   C  registered ROM magnitude reads
//   D  sign application into the output registers
//
// Parameters:
//   PHASE_W  accumulator / FCW / offset width (must be >= LUT_AW+2)
//   LUT_AW   quarter-wave ROM address width (2^LUT_AW entries)
//   OUT_W    signed output width; ROM magnitude width is OUT_W-1
//
// Ports:
//   i_clk     clock, rising edge
//   i_reset   asynchronous active-high reset
//   i_ce      sample request, one sample accepted per clock while high
//   i_fcw_wr  load strobe for i_fcw
//   i_fcw     frequency control word (unsigned, modulo 2^PHASE_W)
//   i_poff    phase offset, sampled with i_ce
//   i_sync    synchronous accumulator clear
//   o_valid   o_sin/o_cos carry a new sample this cycle
//   o_sin     two's-complement sine
//   o_cos     two's-complement cosine
//
// Build option:
//   NCO_DITHER_EN  adds a 16-bit LFSR phase dither below the ROM address
//                  bits before truncation; latency is unchanged.

module nco_iq #(
  parameter int unsigned PHASE_W = 24,
  parameter int unsigned LUT_AW  = 8,
  parameter int unsigned OUT_W   = 8
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_ce,
  input  logic               i_fcw_wr,
  input  logic [PHASE_W-1:0] i_fcw,
  input  logic [PHASE_W-1:0] i_poff,
  input  logic               i_sync,
  output logic               o_valid,
  output logic [OUT_W-1:0]   o_sin,
  output logic [OUT_W-1:0]   o_cos
);

  localparam int unsigned MAG_W  = OUT_W - 1;
  localparam int unsigned DEPTH  = 32'd1 << LUT_AW;
  localparam int unsigned TOP_W  = LUT_AW + 2;
  localparam int unsigned FRAC_W = PHASE_W - TOP_W;

  // pi in Q30, used only to build the ROM contents at elaboration
  localparam longint PI_Q30 = 64'sd3373259426;

  // Quarter-wave entry i = round(A*sin(pi/2*(i+0.5)/DEPTH)), A = 2^MAG_W-1.
  // Fixed-point Taylor series keeps the table pure integer math.
  function automatic logic [MAG_W-1:0] rom_entry(input int unsigned i);
    longint x;
    longint x2;
    longint term;
    longint sum;
    longint amp;
    longint num;
    amp  = (longint'(1) << MAG_W) - 64'sd1;
    x    = (PI_Q30 * longint'(2 * i + 1)) / (longint'(4) << LUT_AW);
    x2   = (x * x) >>> 30;
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    num = (sum * amp + (longint'(1) << 29)) >>> 30;
    if (num < 0)   num = 0;
    if (num > amp) num = amp;
    return MAG_W'(num);
  endfunction

  // Zero-extend a magnitude to OUT_W and optionally negate it
  function automatic logic [OUT_W-1:0] apply_sign(input logic [MAG_W-1:0] mag,
                                                  input logic             neg);
    logic [OUT_W-1:0] ext;
    ext = {1'b0, mag};
    return neg ? (OUT_W'(0) - ext) : ext;
  endfunction

  // ---------------------------------------------------------------------------
  // Quarter-wave ROM contents (constant nets)
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] rom [DEPTH];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_rom
    assign rom[g] = rom_entry(g);
  end

  // ---------------------------------------------------------------------------
  // Stage A: frequency word, accumulator, offset phase
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] acc;
  logic [PHASE_W-1:0] fcw_active;
  logic [PHASE_W-1:0] phase_a;
  logic [PHASE_W-1:0] base_c;
  logic               va;

  // sync restarts the phase at zero for the sample accepted on the same edge
  assign base_c = i_sync ? '0 : acc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc        <= '0;
      fcw_active <= '0;
      phase_a    <= '0;
      va         <= 1'b0;
    end else begin
      // a new FCW only affects samples accepted after this edge
      if (i_fcw_wr) fcw_active <= i_fcw;
      va <= i_ce;
      if (i_ce) begin
        phase_a <= base_c + i_poff;
        acc     <= base_c + fcw_active;
      end else if (i_sync) begin
        acc <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Optional phase dither (LFSR advances once per accepted sample)
  // ---------------------------------------------------------------------------
  logic [PHASE_W-1:0] fold_phase_c;

`ifdef NCO_DITHER_EN
  localparam int unsigned DITH_W    = (FRAC_W > 16) ? 16 : FRAC_W;
  localparam logic [15:0] DITH_MASK = 16'((32'd1 << DITH_W) - 32'd1);

  logic [15:0]        lfsr;
  logic [15:0]        lfsr_next_c;
  logic [PHASE_W-1:0] dith_a;

  // x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form
  assign lfsr_next_c = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lfsr   <= 16'hACE1;
      dith_a <= '0;
    end else if (i_ce) begin
      dith_a <= PHASE_W'(lfsr & DITH_MASK);
      lfsr   <= lfsr_next_c;
    end
  end

  assign fold_phase_c = phase_a + dith_a;
`else
  assign fold_phase_c = phase_a;
`endif

  // ---------------------------------------------------------------------------
  // Stage B: quadrant fold for sine and cosine
  // ---------------------------------------------------------------------------
  logic [TOP_W-1:0]  top_c;
  logic [1:0]        q_c;
  logic [1:0]        qc_c;
  logic [LUT_AW-1:0] idx_c;

  logic [LUT_AW-1:0] addr_s_b;
  logic [LUT_AW-1:0] addr_c_b;
  logic              neg_s_b;
  logic              neg_c_b;
  logic              vb;

  // bits below the ROM address are truncated here
  assign top_c = TOP_W'(fold_phase_c >> FRAC_W);
  assign q_c   = top_c[TOP_W-1 -: 2];
  assign idx_c = top_c[LUT_AW-1:0];
  // cosine is sine a quarter turn ahead
  assign qc_c  = q_c + 2'd1;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_s_b <= '0;
      addr_c_b <= '0;
      neg_s_b  <= 1'b0;
      neg_c_b  <= 1'b0;
      vb       <= 1'b0;
    end else begin
      vb       <= va;
      // odd quadrants read the quarter wave backwards
      addr_s_b <= q_c[0]  ? ~idx_c : idx_c;
      addr_c_b <= qc_c[0] ? ~idx_c : idx_c;
      neg_s_b  <= q_c[1];
      neg_c_b  <= qc_c[1];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage C: registered ROM reads
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] mag_s_c;
  logic [MAG_W-1:0] mag_c_c;
  logic             neg_s_c;
  logic             neg_c_c;
  logic             vc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      mag_s_c <= '0;
      mag_c_c <= '0;
      neg_s_c <= 1'b0;
      neg_c_c <= 1'b0;
      vc      <= 1'b0;
    end else begin
      vc      <= vb;
      mag_s_c <= rom[addr_s_b];
      mag_c_c <= rom[addr_c_b];
      neg_s_c <= neg_s_b;
      neg_c_c <= neg_c_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage D: signed outputs, held between valid samples
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_valid <= 1'b0;
      o_sin   <= '0;
      o_cos   <= '0;
    end else begin
      o_valid <= vc;
      if (vc) begin
        o_sin <= apply_sign(mag_s_c, neg_s_c);
        o_cos <= apply_sign(mag_c_c, neg_c_c);
      end
    end
  end

endmodule

// File: tb/tb_nco_iq.sv
// tb_nco_iq: directed self-checking bench for nco_iq (24/8/8 build,
// dither disabled). Outputs are sampled 1 time unit after each rising edge.

module tb_nco_iq;

  localparam int unsigned PHASE_W = 24;
  localparam int unsigned LUT_AW  = 8;
  localparam int unsigned OUT_W   = 8;
  localparam real         PI      = 3.14159265358979;

  logic               i_clk = 1'b0;
  logic               i_reset;
  logic               i_ce;
  logic               i_fcw_wr;
  logic [PHASE_W-1:0] i_fcw;
  logic [PHASE_W-1:0] i_poff;
  logic               i_sync;
  logic               o_valid;
  logic [OUT_W-1:0]   o_sin;
  logic [OUT_W-1:0]   o_cos;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 i_clk = ~i_clk;

  nco_iq #(
    .PHASE_W(PHASE_W),
    .LUT_AW (LUT_AW),
    .OUT_W  (OUT_W)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_ce    (i_ce),
    .i_fcw_wr(i_fcw_wr),
    .i_fcw   (i_fcw),
    .i_poff  (i_poff),
    .i_sync  (i_sync),
    .o_valid (o_valid),
    .o_sin   (o_sin),
    .o_cos   (o_cos)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic expect_out(input string tag, input int v, input int s, input int c);
    check({tag, "_valid"}, int'(o_valid), v);
    check({tag, "_sin"}, int'($signed(o_sin)), s);
    check({tag, "_cos"}, int'($signed(o_cos)), c);
  endtask

  task automatic load_fcw(input logic [PHASE_W-1:0] f);
    i_fcw    = f;
    i_fcw_wr = 1'b1;
    tick();
    i_fcw_wr = 1'b0;
  endtask

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    else          return -int'($floor(-x + 0.5));
  endfunction

  initial begin
    int qs [4] = '{0, 127, 0, -127};
    int qc [4] = '{127, 0, -127, 0};
    int fs [6] = '{0, 4, 7, 10, 16, 22};
    int fc [6] = '{127, 127, 127, 127, 126, 125};
    int cp [5] = '{1, 0, 1, 1, 0};
    int tv [6] = '{1, 0, 1, 1, 0, 0};
    int ts [6] = '{0, 0, 7, 13, 13, 13};
    int tc [6] = '{127, 127, 127, 126, 126, 126};
    int max_v;
    int min_v;

    i_reset  = 1'b1;
    i_ce     = 1'b1;
    i_fcw_wr = 1'b0;
    i_fcw    = '0;
    i_poff   = '0;
    i_sync   = 1'b0;

    // reset held with i_ce high: nothing comes out
    for (int n = 0; n < 3; n++) begin
      tick();
      expect_out("reset", 0, 0, 0);
    end
    i_reset = 1'b0;
    i_ce    = 1'b0;
    tick();

    // quarter-turn steps: quadrature pattern, then hold
    load_fcw(24'h400000);
    i_sync = 1'b1;
    i_ce   = 1'b1;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (n == 0) i_sync = 1'b0;
      if (n == 7) i_ce = 1'b0;
      if (n < 3)       check("quad_idle", int'(o_valid), 0);
      else if (n < 11) expect_out("quad", 1, qs[(n - 3) % 4], qc[(n - 3) % 4]);
      else             expect_out("quad_hold", 0, -127, 0);
    end

    // single sample at 45 degrees (ROM[128] and ROM[127])
    load_fcw(24'h000000);
    i_poff = 24'h200000;
    i_sync = 1'b1;
    i_ce   = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n == 0) begin
        i_ce   = 1'b0;
        i_sync = 1'b0;
      end
      if (n < 3)       check("single_idle", int'(o_valid), 0);
      else if (n == 3) expect_out("single", 1, 90, 90);
      else             expect_out("single_hold", 0, 90, 90);
    end

    // FCW change mid-stream: phases 0,1,2,3,5,7 x 0x10000
    load_fcw(24'h010000);
    i_poff = '0;
    i_sync = 1'b1;
    i_ce   = 1'b1;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (n == 0) i_sync = 1'b0;
      if (n == 1) begin
        i_fcw    = 24'h020000;
        i_fcw_wr = 1'b1;
      end
      if (n == 2) i_fcw_wr = 1'b0;
      if (n == 5) i_ce = 1'b0;
      if (n < 3)       check("fcw_idle", int'(o_valid), 0);
      else if (n < 9)  expect_out("fcw", 1, fs[n - 3], fc[n - 3]);
      else             expect_out("fcw_hold", 0, 22, 125);
    end

    // sync alone clears acc, then gapped i_ce with step 0x20000
    i_sync = 1'b1;
    i_ce   = 1'b0;
    tick();
    i_sync = 1'b0;
    for (int n = 0; n < 9; n++) begin
      i_ce = (n < 5) ? cp[n][0] : 1'b0;
      tick();
      if (n < 3) check("gap_idle", int'(o_valid), 0);
      else       expect_out("gap", tv[n - 3], ts[n - 3], tc[n - 3]);
    end

    // reset asserted mid-stream clears outputs without waiting for a clock
    i_poff = 24'h200000;
    i_ce   = 1'b1;
    for (int n = 0; n < 4; n++) tick();
    check("pre_reset_valid", int'(o_valid), 1);
    #3;
    i_reset = 1'b1;
    #1;
    expect_out("async_reset", 0, 0, 0);
    tick();
    i_reset = 1'b0;
    i_poff  = '0;
    // fcw_active and acc are zero again: phase 0 sample
    for (int n = 0; n < 5; n++) begin
      tick();
      if (n == 0) i_ce = 1'b0;
      if (n < 3)       expect_out("post_reset_flush", 0, 0, 0);
      else if (n == 3) expect_out("post_reset", 1, 0, 127);
      else             expect_out("post_reset_hold", 0, 0, 127);
    end

    // full-cycle sweep against an analytic model
    load_fcw(24'h000100);
    i_sync = 1'b1;
    i_ce   = 1'b1;
    max_v  = -1000;
    min_v  = 1000;
    for (int n = 0; n < 65539; n++) begin
      tick();
      if (n == 0) i_sync = 1'b0;
      if (n == 65535) i_ce = 1'b0;
      if (n >= 3) begin
        int  m;
        int  b;
        int  s;
        int  c;
        real th;
        m  = n - 3;
        b  = (m >> 6) & 1023;
        th = 2.0 * PI * (real'(b) + 0.5) / 1024.0;
        expect_out("sweep", 1, rnd(127.0 * $sin(th)), rnd(127.0 * $cos(th)));
        s = int'($signed(o_sin));
        c = int'($signed(o_cos));
        if (s > max_v) max_v = s;
        if (c > max_v) max_v = c;
        if (s < min_v) min_v = s;
        if (c < min_v) min_v = c;
      end
    end
    tick();
    check("sweep_end_valid", int'(o_valid), 0);
    check("sweep_max", max_v, 127);
    check("sweep_min", min_v, -127);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
